// File: rtl/neureka_tcdm_target_adapter.sv
`default_nettype none
// ============================================================================
// Module      : neureka_tcdm_target_adapter
// Description : HCI/TCDM responder driving a single-port SRAM, with in-order,
//               credit-limited fall-through response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module neureka_tcdm_target_adapter #(
    parameter int unsigned DW             = 256,
    parameter int unsigned AW             = 32,
    parameter int unsigned IW             = 8,
    parameter int unsigned NB_WORDS       = 1024,
    parameter int unsigned SRAM_LATENCY   = 1,
    parameter int unsigned RSP_FIFO_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        tcdm_req_i,
    output logic                        tcdm_gnt_o,
    input  logic [AW-1:0]               tcdm_add_i,
    input  logic                        tcdm_wen_i,
    input  logic [DW/8-1:0]             tcdm_be_i,
    input  logic [DW-1:0]               tcdm_data_i,
    input  logic [IW-1:0]               tcdm_id_i,
    output logic [DW-1:0]               tcdm_r_data_o,
    output logic                        tcdm_r_valid_o,
    input  logic                        tcdm_r_ready_i,
    output logic [IW-1:0]               tcdm_r_id_o,
    output logic                        tcdm_r_opc_o,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [$clog2(NB_WORDS)-1:0] mem_addr_o,
    output logic [DW-1:0]               mem_wdata_o,
    output logic [DW/8-1:0]             mem_be_o,
    input  logic [DW-1:0]               mem_rdata_i,
    output logic                        busy_o
);

    localparam int unsigned c_off = $clog2(DW / 8);
    localparam int unsigned c_maw = $clog2(NB_WORDS);
    localparam int unsigned c_cw  = $clog2(RSP_FIFO_DEPTH + 1);
    localparam int unsigned c_pw  = $clog2(RSP_FIFO_DEPTH);
    // Byte-address limit: idx >= NB_WORDS  <=>  add >= NB_WORDS * bytes/word
    localparam logic [AW:0] c_lim = (AW+1)'(NB_WORDS * (DW / 8));

    typedef struct packed {
        logic          vld;
        logic          rd;
        logic          err;
        logic [IW-1:0] id;
    } slot_t;

    slot_t            r_pipe [SRAM_LATENCY];
    slot_t            w_out;
    logic [c_cw-1:0]  r_credit;
    logic [c_cw-1:0]  r_count;
    logic [c_pw-1:0]  r_wptr;
    logic [c_pw-1:0]  r_rptr;
    logic [DW-1:0]    r_fdata [RSP_FIFO_DEPTH];
    logic [IW-1:0]    r_fid   [RSP_FIFO_DEPTH];
    logic             r_fopc  [RSP_FIFO_DEPTH];

    logic             w_err;
    logic             w_gnt;
    logic             w_inflight;
    logic             w_push;
    logic [DW-1:0]    w_push_data;
    logic             w_empty;
    logic             w_rvalid;
    logic             w_pop;
    logic             w_wr;
    logic             w_rd;

    // ---------------- request side ----------------
    assign w_err       = ({1'b0, tcdm_add_i} >= c_lim);
    assign w_gnt       = tcdm_req_i & (r_credit != '0) & ~clear_i;
    assign tcdm_gnt_o  = w_gnt;
    assign mem_req_o   = w_gnt & ~w_err;
    assign mem_we_o    = mem_req_o & ~tcdm_wen_i;
    assign mem_addr_o  = mem_req_o ? tcdm_add_i[c_off +: c_maw] : '0;
    assign mem_wdata_o = mem_req_o ? tcdm_data_i : '0;
    assign mem_be_o    = mem_req_o ? tcdm_be_i : '0;

    // Pipeline tracks the SRAM read latency so each entry meets its data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SRAM_LATENCY; i++) r_pipe[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < SRAM_LATENCY; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= '{vld: w_gnt, rd: tcdm_wen_i, err: w_err, id: tcdm_id_i};
            for (int i = 1; i < SRAM_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    always_comb begin
        w_inflight = 1'b0;
        for (int i = 0; i < SRAM_LATENCY; i++) w_inflight = w_inflight | r_pipe[i].vld;
    end

    assign w_out       = r_pipe[SRAM_LATENCY-1];
    assign w_push      = w_out.vld & ~clear_i;
    assign w_push_data = (w_out.rd & ~w_out.err) ? mem_rdata_i : '0;

    // ---------------- response FIFO (fall-through) ----------------
    assign w_empty  = (r_count == '0);
    assign w_rvalid = ~clear_i & (~w_empty | w_push);
    assign w_pop    = w_rvalid & tcdm_r_ready_i;
    // An entry that arrives into an empty FIFO and is accepted at once bypasses storage
    assign w_wr     = w_push & ~(w_empty & w_pop);
    assign w_rd     = w_pop & ~w_empty;

    assign tcdm_r_valid_o = w_rvalid;
    assign tcdm_r_data_o  = !w_rvalid ? '0   : (w_empty ? w_push_data : r_fdata[r_rptr]);
    assign tcdm_r_id_o    = !w_rvalid ? '0   : (w_empty ? w_out.id    : r_fid[r_rptr]);
    assign tcdm_r_opc_o   = !w_rvalid ? 1'b0 : (w_empty ? w_out.err   : r_fopc[r_rptr]);
    assign busy_o         = ~w_empty | w_inflight;

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_fdata[r_wptr] <= w_push_data;
            r_fid[r_wptr]   <= w_out.id;
            r_fopc[r_wptr]  <= w_out.err;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_credit <= c_cw'(RSP_FIFO_DEPTH);
        end else if (clear_i) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_credit <= c_cw'(RSP_FIFO_DEPTH);
        end else begin
            if (w_wr) r_wptr <= (r_wptr == c_pw'(RSP_FIFO_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            if (w_rd) r_rptr <= (r_rptr == c_pw'(RSP_FIFO_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            r_count  <= r_count + c_cw'(w_wr) - c_cw'(w_rd);
            r_credit <= r_credit + c_cw'(w_pop) - c_cw'(w_gnt);
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (w_push && r_count == c_cw'(RSP_FIFO_DEPTH)) |-> w_pop);
`endif

endmodule
`default_nettype wire

// File: doc/neureka_tcdm_target_adapter.md
Name: neureka_tcdm_target_adapter

Overview:
TCDM target (responder) that terminates an hci_core request/response stream and drives a single-port SRAM macro, such as the dedicated weight memory.
- Accepts granted reads and writes and issues SRAM accesses.
- Returns exactly one in-order response per granted request, carrying r_id and an error opcode.
- Absorbs r_ready backpressure through a credit-limited response FIFO.
- Sits between the cluster interconnect/streamer initiator side and the wmem macro.

Parameters:
DW, 256, data width in bits; DW is a multiple of 8.
AW, 32, byte address width.
IW, 8, transaction ID width.
NB_WORDS, 1024, SRAM depth in DW-bit words.
SRAM_LATENCY, 1, cycles from mem_req_o to valid mem_rdata_i; range 1..3.
RSP_FIFO_DEPTH, 4, response FIFO depth; must be at least SRAM_LATENCY+1.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous flush
tcdm_req_i  in  1  request valid
tcdm_gnt_o  out  1  request grant
tcdm_add_i  in  AW  byte address
tcdm_wen_i  in  1  1=read, 0=write (HCI convention)
tcdm_be_i  in  DW/8  byte enables
tcdm_data_i  in  DW  write data
tcdm_id_i  in  IW  request ID
tcdm_r_data_o  out  DW  response data
tcdm_r_valid_o  out  1  response valid
tcdm_r_ready_i  in  1  response accept
tcdm_r_id_o  out  IW  response ID
tcdm_r_opc_o  out  1  1 = address-range error
mem_req_o  out  1  SRAM access strobe
mem_we_o  out  1  SRAM write enable
mem_addr_o  out  clog2(NB_WORDS)  SRAM word index
mem_wdata_o  out  DW  SRAM write data
mem_be_o  out  DW/8  SRAM byte enables
mem_rdata_i  in  DW  SRAM read data
busy_o  out  1  any transaction in flight or queued

Behaviour:
- Reset (rst_ni low, asynchronous): all outputs 0, FIFO empty, in-flight pipeline empty, credit counter = RSP_FIFO_DEPTH.
- Word index: idx = tcdm_add_i >> log2(DW/8); low address bits are ignored.
  - Range error when idx >= NB_WORDS.
- Credits: credit = RSP_FIFO_DEPTH - fifo_count - inflight_count.
  - Granting a request decrements credit.
  - A FIFO pop (r_valid & r_ready) increments credit.
  - Both in the same cycle leave credit unchanged.
- Grant: tcdm_gnt_o = tcdm_req_i & (credit > 0) & ~clear_i. It is combinational and depends on no response-side input in the same cycle.
- Memory access on a grant with no range error, same cycle:
  - mem_req_o=1, mem_we_o=~tcdm_wen_i;
  - mem_addr_o = idx truncated to clog2(NB_WORDS) bits;
  - mem_wdata_o and mem_be_o driven from the request.
- Memory access on a grant with a range error: mem_req_o=0 (the SRAM is not touched), but the transaction still consumes a credit and produces a response.
- Pipeline: a shift register of depth SRAM_LATENCY carries {valid, is_read, err, id} per slot.
  - At the output slot, the entry pushes into the FIFO.
  - Push data = mem_rdata_i for a valid read; 0 for a write or an error.
  - opc = err.
- Response FIFO: fall-through.
  - When the FIFO is empty, r_valid rises in the same cycle the entry leaves the pipeline.
  - Read-response latency is SRAM_LATENCY cycles after the grant cycle.
  - r_data, r_id and r_opc hold stable while r_valid=1 and r_ready=0.
- Responses are strictly in grant order; no reordering.
- The FIFO never overflows by construction. A push while full is an assertion error (simulation only).
- Push and pop in the same cycle on a full FIFO: both are legal and the count is unchanged.
- clear_i: on the next edge, flush the pipeline and FIFO and restore credit.
  - tcdm_gnt_o=0 and tcdm_r_valid_o=0 during the clear cycle.
  - An SRAM write already issued in an earlier cycle is not undone.
- busy_o = (fifo_count != 0) | (inflight_count != 0).
- Back-to-back grants at one per cycle are sustained while r_ready=1.

Test Plan:
1. Write word 5 (add=0xA0, DW=256, be=all 1s, data=0xDEAD…) then read add=0xA0 with id=3 -> write response with r_opc=0 and r_data=0; then read response r_data=0xDEAD…, r_id=3, r_valid SRAM_LATENCY cycles after the read grant.
2. Hold r_ready=0 and issue 6 reads (depth 4) -> exactly 4 grants, gnt low thereafter. Raise r_ready -> 4 responses in ID order, then remaining grants resume with one credit restored per pop.
3. Read add = NB_WORDS*32 (out of range) -> mem_req_o stays 0; response r_opc=1, r_data=0, correct r_id.
4. Continuous reads with r_ready=1 and SRAM_LATENCY=2 -> gnt high every cycle; r_valid continuous from cycle 2 with IDs in order.
5. Partial write be=0x0000_000F on a word pre-filled with 0xFF… then read back -> only the low 4 bytes change.
6. Assert clear_i with 3 responses queued and 1 in flight -> next cycle r_valid=0, busy_o=0, credit=4; a subsequent read completes normally.
